// File: rtl/amm_rd_arbiter.sv
// Two-master Avalon-MM read arbiter with round-robin grant and an in-order ID FIFO
// that steers each slave readdatavalid beat back to the master that issued the read.
module amm_rd_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int MAX_PENDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_address_i,
   input  logic                  m0_read_i,
   output logic [DATA_WIDTH-1:0] m0_readdata_o,
   output logic                  m0_readdatavalid_o,
   output logic                  m0_waitrequest_o,
   input  logic [ADDR_WIDTH-1:0] m1_address_i,
   input  logic                  m1_read_i,
   output logic [DATA_WIDTH-1:0] m1_readdata_o,
   output logic                  m1_readdatavalid_o,
   output logic                  m1_waitrequest_o,
   output logic [ADDR_WIDTH-1:0] s_address_o,
   output logic                  s_read_o,
   input  logic [DATA_WIDTH-1:0] s_readdata_i,
   input  logic                  s_readdatavalid_i,
   input  logic                  s_waitrequest_i,
   output logic                  err_o
);

   localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int CW = $clog2(MAX_PENDING + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_PENDING - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PENDING);

   logic                   last_gnt_q, last_gnt_d;
   logic [MAX_PENDING-1:0] id_q, id_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          pend_q, pend_d;
   logic                   err_q, err_d;

   logic gnt_vld, gnt_id, full, empty, accept, pop, head_id;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // Grant: lone requester wins; on a tie the master not granted last time wins.
   always_comb begin
      gnt_vld = m0_read_i | m1_read_i;
      gnt_id  = 1'b0;
      if (m0_read_i && m1_read_i) gnt_id = ~last_gnt_q;
      else if (m1_read_i)         gnt_id = 1'b1;
   end

   // Full is taken from the registered count, so a pop in the same cycle does not unblock.
   assign full  = (pend_q == CNT_MAX);
   assign empty = (pend_q == '0);

   assign s_read_o    = gnt_vld & ~full & ~rst;
   assign s_address_o = gnt_id ? m1_address_i : m0_address_i;
   assign accept      = s_read_o & ~s_waitrequest_i;

   assign m0_waitrequest_o = ~(accept & ~gnt_id);
   assign m1_waitrequest_o = ~(accept &  gnt_id);

   assign head_id = id_q[rd_ptr_q];
   assign pop     = s_readdatavalid_i & ~empty & ~rst;

   assign m0_readdatavalid_o = pop & ~head_id;
   assign m1_readdatavalid_o = pop &  head_id;
   assign m0_readdata_o      = s_readdata_i;
   assign m1_readdata_o      = s_readdata_i;
   assign err_o              = err_q;

   always_comb begin
      last_gnt_d = last_gnt_q;
      id_d       = id_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pend_d     = pend_q;
      err_d      = err_q;
      if (accept) begin
         id_d[wr_ptr_q] = gnt_id;
         wr_ptr_d       = ptr_inc(wr_ptr_q);
         last_gnt_d     = gnt_id;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({accept, pop})
         2'b10:   pend_d = pend_q + CW'(1);
         2'b01:   pend_d = pend_q - CW'(1);
         default: pend_d = pend_q;
      endcase
      if (s_readdatavalid_i && empty) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_q <= 1'b1;
         id_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pend_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         last_gnt_q <= last_gnt_d;
         id_q       <= id_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pend_q     <= pend_d;
         err_q      <= err_d;
      end
   end

endmodule
